adder_rr_sched: RTL and testbench

- Round-robin scheduler that shares one registered W-bit adder among NREQ requesters.
- Sits between the top-level pin wrapper and the adder datapath; each requester posts an operand pair and receives a single ack.
- Results come back on one shared valid/ready port, tagged with the requester id.
- Throughput: one operation per 3 cycles minimum. No operation is ever dropped or reordered within a requester.

---
 rtl/adder_pkg.sv | 33 +++
 rtl/adder_rr_pick.sv | 22 ++
 rtl/adder_rr_sched.sv | 135 +++++++++++++
 tb/tb_adder_rr_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types, defaults and round-robin search helper for adder_rr_sched
package adder_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 2;
  localparam int MAX_NREQ = 8;
  localparam int MAX_IDW  = 3;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} sched_state_t;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } pick_t;

  // First set bit of req at or above ptr, wrapping modulo nreq.
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                    input logic [MAX_IDW-1:0]  ptr,
                                    input int                  nreq);
    pick_t r;
    int    j;
    r = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      j = (int'(ptr) + i) % nreq;
      if (!r.found && i < nreq && req[j]) begin
        r.found = 1'b1;
        r.idx   = MAX_IDW'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_rr_pick.sv
// rtl/adder_rr_pick.sv - combinational round-robin priority encoder (req, ptr -> idx, any)
module adder_rr_pick
  import adder_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  pick_t p;

  always_comb begin
    p     = rr_pick(MAX_NREQ'(req_i), MAX_IDW'(ptr_i), NREQ);
    idx_o = IDW'(p.idx);
    any_o = p.found;
  end

endmodule

// File: rtl/adder_rr_sched.sv
// rtl/adder_rr_sched.sv - round-robin scheduler sharing one registered adder among NREQ requesters
// Optional per-requester grant counters with macro ADDER_RR_SCHED_STATS_EN.
module adder_rr_sched
  import adder_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  parameter  int W    = DEF_W,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  output logic [NREQ-1:0]   ack,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W:0]        res_sum,
  output logic [IDW-1:0]    res_id,
`ifdef ADDER_RR_SCHED_STATS_EN
  input  logic              stats_clr,
  output logic [NREQ*8-1:0] grant_cnt,
`endif
  output logic              busy
);

  sched_state_t    state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  g_q, g_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            valid_q, valid_d;
  logic [W:0]      sum_q, sum_d;
  logic [IDW-1:0]  id_q, id_d;

  logic [IDW-1:0]  pick_idx;
  logic            pick_any;

  adder_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    a_d     = a_q;
    b_d     = b_q;
    ack_d   = '0;
    valid_d = valid_q;
    sum_d   = sum_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          a_d     = op_a[pick_idx*W +: W];
          b_d     = op_b[pick_idx*W +: W];
          g_d     = pick_idx;
          ack_d   = NREQ'(1) << pick_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        sum_d   = (W+1)'(a_q) + (W+1)'(b_q);
        id_d    = g_q;
        valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        // Pointer only moves on handshake, so a stalled consumer never skips anyone.
        if (res_ready) begin
          valid_d = 1'b0;
          ptr_d   = g_q + IDW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ack_q   <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
    end
  end

  assign ack       = ack_q;
  assign res_valid = valid_q;
  assign res_sum   = sum_q;
  assign res_id    = id_q;
  assign busy      = (state_q != IDLE);

`ifdef ADDER_RR_SCHED_STATS_EN
  logic [7:0] cnt_q [NREQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (stats_clr) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (ack_q[i] && cnt_q[i] != 8'hFF) cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) grant_cnt[i*8 +: 8] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_adder_rr_sched.sv
// tb/tb_adder_rr_sched.sv - self-checking bench for adder_rr_sched (transaction model + directed vectors)
module tb_adder_rr_sched;

  localparam int NREQ = 4;
  localparam int W    = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] op_a = '0;
  logic [7:0] op_b = '0;
  logic       res_ready = 1'b0;
  logic [3:0] ack;
  logic       res_valid;
  logic [2:0] res_sum;
  logic [1:0] res_id;
  logic       busy;
`ifdef ADDER_RR_SCHED_STATS_EN
  logic        stats_clr = 1'b0;
  logic [31:0] grant_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  adder_rr_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .ack       (ack),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id),
`ifdef ADDER_RR_SCHED_STATS_EN
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one operation in flight, aged in cycles since its grant.
  bit m_inflight;
  int m_age, m_id, m_sum, m_ptr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_inflight = 0;
      m_ptr      = 0;
      m_age      = 0;
    end else if (!m_inflight) begin
      for (int i = 0; i < NREQ; i++) begin
        int j;
        j = (m_ptr + i) % NREQ;
        if (!m_inflight && req[j]) begin
          m_inflight = 1;
          m_id       = j;
          m_age      = 0;
          m_sum      = int'(op_a[j*W +: W]) + int'(op_b[j*W +: W]);
        end
      end
    end else if (m_age >= 1 && res_ready) begin
      m_inflight = 0;
      m_ptr      = (m_id + 1) % NREQ;
    end else begin
      m_age++;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_ack", int'(ack), (m_inflight && m_age == 0) ? (1 << m_id) : 0);
      chk("model_valid", int'(res_valid), int'(m_inflight && m_age >= 1));
      chk("model_busy", int'(busy), int'(m_inflight));
      if (m_inflight && m_age >= 1) begin
        chk("model_sum", int'(res_sum), m_sum);
        chk("model_id", int'(res_id), m_id);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input int a, input int b);
    op_a[i*W +: W] = W'(a);
    op_b[i*W +: W] = W'(b);
  endtask

  task automatic wait_ack(output logic [3:0] a);
    a = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack != 0) begin
        a = ack;
        return;
      end
    end
    chk("ack_seen", int'(ack != 0), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] a;
    int got[$];
    int when[$];
    int grants;

    repeat (2) tick();
    chk("rst_ack", int'(ack), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_sum", int'(res_sum), 0);
    chk("rst_id", int'(res_id), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    res_ready = 1'b1;
    tick();

    // Single request 2+3
    set_op(0, 2, 3);
    req = 4'b0001;
    tick();
    chk("single_ack", int'(ack), 1);
    chk("single_busy", int'(busy), 1);
    req = 4'b0000;
    tick();
    chk("single_valid", int'(res_valid), 1);
    chk("single_sum", int'(res_sum), 5);
    chk("single_id", int'(res_id), 0);
    tick();
    chk("single_idle_busy", int'(busy), 0);
    chk("single_idle_valid", int'(res_valid), 0);

    // All requesting from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < NREQ; i++) set_op(i, i, (i + 1) % 4);
    req = 4'b1111;
    for (int c = 0; c < 30 && got.size() < 5; c++) begin
      tick();
      if (ack != 0) begin
        got.push_back($clog2(ack));
        when.push_back(c);
      end
    end
    req = 4'b0000;
    chk("all_count", got.size(), 5);
    for (int k = 0; k < got.size(); k++) begin
      chk("all_order", got[k], k % 4);
      if (k > 0) chk("all_period", when[k] - when[k-1], 3);
    end
    repeat (3) tick();

    // Backpressure on requester 2, requester 1 waiting
    set_op(2, 3, 1);
    res_ready = 1'b0;
    req = 4'b0100;
    wait_ack(a);
    chk("bp_ack", int'(a), 4);
    set_op(1, 1, 1);
    req = 4'b0010;
    tick();
    chk("bp_valid0", int'(res_valid), 1);
    repeat (10) begin
      tick();
      chk("bp_noack", int'(ack), 0);
      chk("bp_valid", int'(res_valid), 1);
      chk("bp_sum", int'(res_sum), 4);
      chk("bp_id", int'(res_id), 2);
    end
    res_ready = 1'b1;
    tick();
    chk("bp_release_valid", int'(res_valid), 0);
    tick();
    chk("bp_next_ack", int'(ack), 2);
    req = 4'b0000;
    repeat (3) tick();

    // Overflow and wrap: bring ptr to 3, grant 3 with 3+3
    set_op(2, 0, 0);
    req = 4'b0100;
    wait_ack(a);
    req = 4'b0000;
    repeat (3) tick();
    set_op(3, 3, 3);
    req = 4'b1000;
    wait_ack(a);
    chk("ovf_ack", int'(a), 8);
    req = 4'b0000;
    tick();
    chk("ovf_sum", int'(res_sum), 6);
    chk("ovf_id", int'(res_id), 3);
    tick();
    set_op(0, 1, 0);
    req = 4'b1001;
    wait_ack(a);
    chk("wrap_first", int'(a), 1);
    wait_ack(a);
    chk("wrap_second", int'(a), 8);
    req = 4'b0000;
    repeat (3) tick();

    // Reset mid-operation with ptr left at 3
    set_op(2, 0, 1);
    req = 4'b0100;
    wait_ack(a);
    req = 4'b0000;
    repeat (3) tick();
    res_ready = 1'b0;
    req = 4'b0010;
    wait_ack(a);
    req = 4'b0000;
    tick();
    chk("mid_valid", int'(res_valid), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", int'(res_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ack", int'(ack), 0);
    tick();
    reset = 1'b0;
    res_ready = 1'b1;
    tick();
    chk("post_rst_ack", int'(ack), 0);
    chk("post_rst_valid", int'(res_valid), 0);
    req = 4'b1100;
    wait_ack(a);
    chk("post_rst_ptr0", int'(a), 4);
    req = 4'b0000;
    repeat (3) tick();

`ifdef ADDER_RR_SCHED_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    set_op(1, 1, 2);
    req = 4'b0010;
    grants = 0;
    for (int c = 0; c < 1000 && grants < 300; c++) begin
      tick();
      if (ack[1]) grants++;
    end
    req = 4'b0000;
    chk("stats_grants", grants, 300);
    repeat (3) tick();
    chk("stats_sat", int'(grant_cnt[15:8]), 255);
    req = 4'b0010;
    wait_ack(a);
    stats_clr = 1'b1;
    req = 4'b0000;
    tick();
    stats_clr = 1'b0;
    chk("stats_clr", int'(grant_cnt[15:8]), 0);
    repeat (3) tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
